instr_issue_queue: RTL and testbench

- Parametrised instruction issue buffer that sits in front of the `arm` core's `Instruction` input.
- Benches, and later the camera/loader path, push 32-bit instruction words into a FIFO. The block then issues one word per cycle.
- It automatically inserts NOP words when a queued instruction reads a register still in flight in the core pipeline. This replaces hand-placed NOPs in stimulus.
- Depth, hazard window and NOP encoding are configurable.

---
 rtl/instr_issue_queue.sv | 140 ++++++++++++++
 tb/tb_instr_issue_queue.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// Instruction issue buffer for the arm core: a FIFO of 32-bit words that
// issues one word per cycle and inserts NOP_WORD while the head reads a
// register whose producer is still inside the hazard window.
module instr_issue_queue #(
    parameter int          DEPTH         = 8,
    parameter int          HAZARD_WINDOW = 3,
    parameter logic [31:0] NOP_WORD      = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [31:0]                  push_instr,
    input  logic                         flush,
    input  logic                         stall,
    output logic [31:0]                  Instruction,
    output logic                         issued_valid,
    output logic                         nop_inserted,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [HAZARD_WINDOW-1:0] sb_valid;
    logic [3:0]               sb_rd [HAZARD_WINDOW];

    logic [31:0] head;
    logic        hazard;
    logic        push_acc;
    logic        pop;

    // Destination register is written by data-processing ops except the
    // compare/test group (cmd 10xx), and by loads.
    function automatic logic dst_writes(input logic [31:0] w);
        logic wr;
        wr = 1'b0;
        case (w[27:26])
            2'b00:   wr = (w[24:23] != 2'b10);
            2'b01:   wr = w[20];
            default: wr = 1'b0;
        endcase
        return wr;
    endfunction

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        logic reads_rn;
        logic reads_rm;
        logic reads_rd;
        reads_rn = (head[27:26] == 2'b00) || (head[27:26] == 2'b01);
        reads_rm = (head[27:26] == 2'b00) && !head[25];
        reads_rd = (head[27:26] == 2'b01) && !head[20];
        hazard   = 1'b0;
        for (int i = 0; i < HAZARD_WINDOW; i++) begin
            if (sb_valid[i] &&
                ((reads_rn && head[19:16] == sb_rd[i]) ||
                 (reads_rm && head[3:0]   == sb_rd[i]) ||
                 (reads_rd && head[15:12] == sb_rd[i])))
                hazard = 1'b1;
        end
    end

    // Push handshake: push is a request with full as its inverse ready,
    // both sampled at the same edge; a word is taken only when full=0 and
    // flush=0, and a same-cycle pop never makes room for it.
    assign push_acc = push && !full && !flush;
    assign pop      = !flush && !stall && !empty && !hazard;

    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wr_ptr] <= push_instr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            Instruction  <= NOP_WORD;
            issued_valid <= 1'b0;
            nop_inserted <= 1'b0;
            sb_valid     <= '0;
            for (int i = 0; i < HAZARD_WINDOW; i++)
                sb_rd[i] <= '0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            Instruction  <= NOP_WORD;
            issued_valid <= 1'b0;
            nop_inserted <= 1'b0;
            sb_valid     <= '0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (push && full)
                overflow <= 1'b1;

            case ({push_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A stalled core freezes the whole issue stage, scoreboard included.
            if (!stall) begin
                if (pop) begin
                    rd_ptr       <= rd_ptr + 1'b1;
                    Instruction  <= head;
                    issued_valid <= 1'b1;
                    nop_inserted <= 1'b0;
                end else begin
                    Instruction  <= NOP_WORD;
                    issued_valid <= 1'b0;
                    nop_inserted <= !empty;
                end
                for (int i = HAZARD_WINDOW - 1; i > 0; i--) begin
                    sb_valid[i] <= sb_valid[i-1];
                    sb_rd[i]    <= sb_rd[i-1];
                end
                sb_valid[0] <= pop && dst_writes(head);
                sb_rd[0]    <= head[15:12];
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_instr_issue_queue;

    localparam int          DEPTH = 8;
    localparam int          HW    = 3;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam int          CW    = $clog2(DEPTH+1);

    localparam logic [31:0] ADD_R1  = 32'h02931001;
    localparam logic [31:0] SUB_R1  = 32'h02512001;
    localparam logic [31:0] SUB_R3  = 32'h02532001;
    localparam logic [31:0] CMP_R1  = 32'h03510001;

    logic          clk;
    logic          reset;
    logic          push;
    logic [31:0]   push_instr;
    logic          flush;
    logic          stall;
    logic [31:0]   Instruction;
    logic          issued_valid;
    logic          nop_inserted;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    instr_issue_queue #(.DEPTH(DEPTH), .HAZARD_WINDOW(HW), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .push(push), .push_instr(push_instr),
        .flush(flush), .stall(stall), .Instruction(Instruction),
        .issued_valid(issued_valid), .nop_inserted(nop_inserted),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: the pending words as a queue and the recently issued
    // slots as a list of {writes, rd}, newest first.
    typedef struct packed { logic v; logic [3:0] r; } slot_t;
    logic [31:0] m_q[$];
    slot_t       hist_q[$];
    logic [31:0] m_instr;
    logic        m_iv, m_ni, m_ovf;
    logic [31:0] exp_q[$];

    function automatic bit m_writes(input logic [31:0] w);
        if (w[27:26] == 2'b00) return !(w[24:21] inside {4'd8, 4'd9, 4'd10, 4'd11});
        if (w[27:26] == 2'b01) return w[20];
        return 1'b0;
    endfunction

    function automatic bit m_hazard(input logic [31:0] w);
        logic [3:0] srcs[$];
        if (w[27:26] == 2'b00 || w[27:26] == 2'b01) srcs.push_back(w[19:16]);
        if (w[27:26] == 2'b00 && !w[25])            srcs.push_back(w[3:0]);
        if (w[27:26] == 2'b01 && !w[20])            srcs.push_back(w[15:12]);
        foreach (hist_q[i])
            if (hist_q[i].v)
                foreach (srcs[j])
                    if (srcs[j] == hist_q[i].r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        hist_q.delete();
        for (int i = 0; i < HW; i++) hist_q.push_back('0);
        m_instr = NOP;
        m_iv    = 1'b0;
        m_ni    = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_edge();
        slot_t s;
        bit    was_full;
        if (!reset || flush) begin
            model_reset();
            return;
        end
        was_full = (m_q.size() == DEPTH);
        if (!stall) begin
            s = '0;
            if (m_q.size() == 0) begin
                m_instr = NOP; m_iv = 1'b0; m_ni = 1'b0;
            end else if (m_hazard(m_q[0])) begin
                m_instr = NOP; m_iv = 1'b0; m_ni = 1'b1;
            end else begin
                m_instr = m_q.pop_front();
                m_iv = 1'b1; m_ni = 1'b0;
                s.v = m_writes(m_instr);
                s.r = m_instr[15:12];
            end
            hist_q.push_front(s);
            void'(hist_q.pop_back());
        end
        if (push) begin
            if (was_full) m_ovf = 1'b1;
            else          m_q.push_back(push_instr);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        push = 1'b0; flush = 1'b0; stall = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; push = 1'b0; push_instr = '0; flush = 1'b0; stall = 1'b0;
        model_reset();
        #12;
        n_tests++;
        if (Instruction !== NOP || issued_valid !== 1'b0 || nop_inserted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_issue: instr=%h iv=%b ni=%b expected %h 0 0", Instruction, issued_valid, nop_inserted, NOP);
        end
        n_tests++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fifo: count=%0d empty=%b full=%b ovf=%b expected 0 1 0 0", count, empty, full, overflow);
        end
        @(negedge clk);
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_dependent_pair();
        idle(4);
        push = 1'b1; push_instr = ADD_R1; tick();
        push_instr = SUB_R1; tick();
        push = 1'b0;
        n_tests++;
        if (Instruction !== ADD_R1 || issued_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dep_first: instr=%h iv=%b expected %h 1", Instruction, issued_valid, ADD_R1);
        end
        for (int j = 1; j <= 3; j++) begin
            tick();
            n_tests++;
            if (Instruction !== NOP || issued_valid !== 1'b0 || nop_inserted !== 1'b1) begin
                n_fail++;
                $display("FAIL dep_nop%0d: instr=%h iv=%b ni=%b expected %h 0 1", j, Instruction, issued_valid, nop_inserted, NOP);
            end
        end
        tick();
        n_tests++;
        if (Instruction !== SUB_R1 || issued_valid !== 1'b1 || nop_inserted !== 1'b0) begin
            n_fail++;
            $display("FAIL dep_second: instr=%h iv=%b ni=%b expected %h 1 0", Instruction, issued_valid, nop_inserted, SUB_R1);
        end
    endtask

    task automatic test_no_hazard(input string name, input logic [31:0] first, input logic [31:0] second);
        idle(4);
        push = 1'b1; push_instr = first; tick();
        push_instr = second; tick();
        push = 1'b0;
        n_tests++;
        if (Instruction !== first || issued_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_first: instr=%h iv=%b expected %h 1", name, Instruction, issued_valid, first);
        end
        tick();
        n_tests++;
        if (Instruction !== second || issued_valid !== 1'b1 || nop_inserted !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_second: instr=%h iv=%b ni=%b expected %h 1 0", name, Instruction, issued_valid, nop_inserted, second);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        logic [31:0] exp_w;
        idle(4);
        exp_q.delete();
        stall = 1'b1; push = 1'b1;
        for (int i = 0; i < 9; i++) begin
            w = $urandom;
            w[27:26] = 2'b10;
            if (i < DEPTH) exp_q.push_back(w);
            push_instr = w;
            tick();
            if (i == DEPTH - 1) begin
                n_tests++;
                if (full !== 1'b1 || count !== CW'(DEPTH) || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full: full=%b count=%0d ovf=%b expected 1 %0d 0", full, count, overflow, DEPTH);
                end
            end
        end
        n_tests++;
        if (count !== CW'(DEPTH) || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: count=%0d ovf=%b expected %0d 1", count, overflow, DEPTH);
        end
        push = 1'b0; stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            exp_w = exp_q.pop_front();
            n_tests++;
            if (Instruction !== exp_w || issued_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: instr=%h iv=%b expected %h 1", i, Instruction, issued_valid, exp_w);
            end
        end
        n_tests++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_empty: empty=%b ovf=%b expected 1 1", empty, overflow);
        end
    endtask

    task automatic test_flush_mid_hazard();
        idle(4);
        push = 1'b1; push_instr = ADD_R1; tick();
        push_instr = SUB_R1; tick();
        push = 1'b0;
        tick();
        tick();
        n_tests++;
        if (nop_inserted !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: ni=%b expected 1", nop_inserted);
        end
        flush = 1'b1; tick();
        flush = 1'b0;
        n_tests++;
        if (count !== '0 || Instruction !== NOP || issued_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: count=%0d instr=%h iv=%b ovf=%b expected 0 %h 0 0", count, Instruction, issued_valid, overflow, NOP);
        end
        push = 1'b1; push_instr = SUB_R1; tick();
        push = 1'b0; tick();
        n_tests++;
        if (Instruction !== SUB_R1 || issued_valid !== 1'b1 || nop_inserted !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: instr=%h iv=%b ni=%b expected %h 1 0", Instruction, issued_valid, nop_inserted, SUB_R1);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] w0;
        idle(4);
        w0 = $urandom;
        w0[27:26] = 2'b10;
        push = 1'b1; push_instr = w0; tick();
        push = 1'b0; tick();
        stall = 1'b1; push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_instr = $urandom;
            tick();
        end
        push = 1'b0;
        n_tests++;
        if (count !== CW'(4) || Instruction !== w0 || issued_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: count=%0d instr=%h iv=%b expected 4 %h 1", count, Instruction, issued_valid, w0);
        end
        #3 reset = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (Instruction !== NOP || issued_valid !== 1'b0 || nop_inserted !== 1'b0 ||
            count !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: instr=%h iv=%b ni=%b count=%0d empty=%b full=%b ovf=%b", Instruction, issued_valid, nop_inserted, count, empty, full, overflow);
        end
        #2 reset = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (issued_valid !== 1'b0 || count !== '0) begin
                n_fail++;
                $display("FAIL areset_after%0d: iv=%b count=%0d expected 0 0", i, issued_valid, count);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int c = 0; c < 600; c++) begin
            push  = ($urandom_range(0, 99) < 70);
            stall = ($urandom_range(0, 99) < 25);
            flush = ($urandom_range(0, 99) < 3);
            w = $urandom;
            w[19:16] = 4'($urandom_range(0, 3));
            w[15:12] = 4'($urandom_range(0, 3));
            w[3:0]   = 4'($urandom_range(0, 3));
            push_instr = w;
            tick();
            n_tests++;
            if (Instruction !== m_instr || issued_valid !== m_iv || nop_inserted !== m_ni ||
                count !== CW'(m_q.size()) || full !== (m_q.size() == DEPTH) ||
                empty !== (m_q.size() == 0) || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random_c%0d: got instr=%h iv=%b ni=%b count=%0d full=%b empty=%b ovf=%b expected %h %b %b %0d %b %b %b",
                         c, Instruction, issued_valid, nop_inserted, count, full, empty, overflow,
                         m_instr, m_iv, m_ni, m_q.size(), (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf);
            end
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_dependent_pair();
        test_no_hazard("indep", ADD_R1, SUB_R3);
        test_no_hazard("cmp", CMP_R1, SUB_R1);
        test_overflow();
        test_flush_mid_hazard();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
